note_uart_tx: RTL and testbench

- Reverse path of the keyboard note decoder: accepts a 4-bit note index (0..13) over a valid/ready handshake.
- Converts the index back to its ASCII letter and transmits it on a UART 8N1 serial line.
- Sits between the piano note logic and the board USB-UART bridge, so played notes are echoed to a PC terminal.

---
 rtl/note_pkg.sv | 36 +++
 rtl/note_to_ascii.sv | 31 +++
 rtl/note_uart_tx.sv | 148 ++++++++++++++
 tb/tb_note_uart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants and FSM state type for the note UART transmit path.
// The CR/LF states exist only when NOTE_TX_CRLF_EN is defined.
package note_pkg;

    localparam logic [3:0] NOTE_C4 = 4'd0;
    localparam logic [3:0] NOTE_D4 = 4'd1;
    localparam logic [3:0] NOTE_E4 = 4'd2;
    localparam logic [3:0] NOTE_F4 = 4'd3;
    localparam logic [3:0] NOTE_G4 = 4'd4;
    localparam logic [3:0] NOTE_A4 = 4'd5;
    localparam logic [3:0] NOTE_B4 = 4'd6;
    localparam logic [3:0] NOTE_C5 = 4'd7;
    localparam logic [3:0] NOTE_D5 = 4'd8;
    localparam logic [3:0] NOTE_E5 = 4'd9;
    localparam logic [3:0] NOTE_F5 = 4'd10;
    localparam logic [3:0] NOTE_G5 = 4'd11;
    localparam logic [3:0] NOTE_A5 = 4'd12;
    localparam logic [3:0] NOTE_B5 = 4'd13;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef NOTE_TX_CRLF_EN
        ,
        ST_CR,
        ST_LF
`endif
    } tx_state_e;

endpackage

// File: rtl/note_to_ascii.sv
// Combinational inverse of the keyboard decoder: note index to ASCII letter.
// Lower octave is lowercase, upper octave uppercase, unused codes give '?'.
module note_to_ascii
    import note_pkg::*;
(
    input  logic [3:0] note_num,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_QMARK;
        case (note_num)
            NOTE_C4: ascii = 8'd99;
            NOTE_D4: ascii = 8'd100;
            NOTE_E4: ascii = 8'd101;
            NOTE_F4: ascii = 8'd102;
            NOTE_G4: ascii = 8'd103;
            NOTE_A4: ascii = 8'd97;
            NOTE_B4: ascii = 8'd98;
            NOTE_C5: ascii = 8'd67;
            NOTE_D5: ascii = 8'd68;
            NOTE_E5: ascii = 8'd69;
            NOTE_F5: ascii = 8'd70;
            NOTE_G5: ascii = 8'd71;
            NOTE_A5: ascii = 8'd65;
            NOTE_B5: ascii = 8'd66;
            default: ascii = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/note_uart_tx.sv
// Accepts a note index over valid/ready and sends its ASCII letter as UART 8N1.
// Define NOTE_TX_CRLF_EN to follow every character with CR and LF frames.
module note_uart_tx
    import note_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] note_num,
    input  logic       note_valid,
    output logic       note_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] last_ascii
);

    localparam int BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       mapped;
    logic             baud_done;

    note_to_ascii u_map (
        .note_num (note_num),
        .ascii    (mapped)
    );

    assign baud_done  = (baud_q == BaudLast);
    assign note_ready = (state_q == ST_IDLE);
    assign busy       = !note_ready;
    assign last_ascii = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
        end
    end

    // CR/LF frames reuse bit_q as a 0..9 position: 0 start, 1..8 data, 9 stop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (note_valid) begin
                    shift_d = mapped;
                    last_d  = mapped;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 4'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
`ifdef NOTE_TX_CRLF_EN
                    bit_d   = '0;
                    shift_d = ASCII_CR;
                    state_d = ST_CR;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef NOTE_TX_CRLF_EN
            ST_CR, ST_LF: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        if (state_q == ST_CR) begin
                            shift_d = ASCII_LF;
                            state_d = ST_LF;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q != 4'd0) begin
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
`ifdef NOTE_TX_CRLF_EN
            ST_CR, ST_LF: begin
                if (bit_q == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_q != 4'd9) begin
                    tx = shift_q[0];
                end
            end
`endif
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_note_uart_tx.sv
// Self-checking bench for note_uart_tx: accepted notes feed a scoreboard queue
// that a UART receiver process drains; direct checks cover timing and reset.
module tb_note_uart_tx;

    localparam int Cpb = 4;
`ifdef NOTE_TX_CRLF_EN
    localparam int FrameCycles = 30 * Cpb;
`else
    localparam int FrameCycles = 10 * Cpb;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] noteNum;
    logic       noteValid;
    logic       noteReady;
    logic       txLine;
    logic       busy;
    logic [7:0] lastAscii;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int rxFrames = 0;
    bit rxActive = 0;
    logic [7:0] expQ[$];

    note_uart_tx #(.CLKS_PER_BIT(Cpb)) dut (
        .clk        (clk),
        .rst        (rst),
        .note_num   (noteNum),
        .note_valid (noteValid),
        .note_ready (noteReady),
        .tx         (txLine),
        .busy       (busy),
        .last_ascii (lastAscii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference map taken straight from the note letter table.
    function automatic logic [7:0] refAscii(input int n);
        string letters;
        letters = "cdefgabCDEFGAB";
        if (n < 14) return letters[n];
        return 8'd63;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Returns right at the accepting edge; cycles counts edges waited.
    task automatic waitAccept(output int cycles);
        bit ok;
        ok = 0;
        cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (noteReady === 1'b1) begin
                @(posedge clk);
                cycles++;
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: no accept within 1000 cycles");
        end
    endtask

    task automatic applyStimulus(input logic [3:0] n);
        int cyc;
        noteNum   = n;
        noteValid = 1'b1;
        waitAccept(cyc);
        #1;
        noteValid = 1'b0;
        noteNum   = 4'($urandom_range(0, 15));
    endtask

    // Scoreboard producer: every accepted note pushes its expected frames.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && noteValid && noteReady) begin
                accepts++;
                expQ.push_back(refAscii(int'(noteNum)));
`ifdef NOTE_TX_CRLF_EN
                expQ.push_back(8'h0D);
                expQ.push_back(8'h0A);
`endif
            end
        end
    end

    // Scoreboard consumer: mid-bit UART receiver sampling on the falling edge.
    initial begin
        int cnt;
        logic [7:0] rxByte;
        forever begin
            @(negedge clk);
            if (rst) begin
                rxActive = 0;
                expQ.delete();
            end else if (!rxActive) begin
                if (txLine === 1'b0) begin
                    rxActive = 1;
                    cnt = 0;
                    rxByte = '0;
                end
            end else begin
                cnt++;
                if (cnt == 2) checkOutput("startBit", int'(txLine), 0);
                for (int b = 0; b < 8; b++)
                    if (cnt == Cpb * (b + 1) + 2) rxByte[b] = txLine;
                if (cnt == Cpb * 9 + 2) begin
                    checkOutput("stopBit", int'(txLine), 1);
                    rxFrames++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", int'(rxByte), -1);
                    end else begin
                        checkOutput("rxByte", int'(rxByte), int'(expQ.pop_front()));
                    end
                    rxActive = 0;
                end
            end
        end
    end

    initial begin
        int n;
        int gap;
        int a0;
        rst       = 1'b1;
        noteValid = 1'b0;
        noteNum   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleTx", int'(txLine), 1);
            checkOutput("idleReady", int'(noteReady), 1);
            checkOutput("idleBusy", int'(busy), 0);
        end
        checkOutput("resetLastAscii", int'(lastAscii), 0);

        @(posedge clk);
        #1;
        applyStimulus(4'd0);
        checkOutput("lastAsciiNote0", int'(lastAscii), 99);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            n = i;
            checkOutput("busyIsNotReady", int'(busy), int'(!noteReady));
            if (noteReady) break;
        end
        checkOutput("readyLatency", n, FrameCycles);

        a0 = accepts;
        noteNum   = 4'd7;
        noteValid = 1'b1;
        waitAccept(gap);
        #1;
        noteNum = 4'd13;
        waitAccept(gap);
        #1;
        noteValid = 1'b0;
        checkOutput("backToBackGap", gap, FrameCycles + 1);
        checkOutput("lastAsciiB", int'(lastAscii), 66);
        repeat (FrameCycles + 20) @(posedge clk);
        #1;
        checkOutput("heldValidAccepts", accepts - a0, 2);

        applyStimulus(4'd14);
        checkOutput("lastAscii14", int'(lastAscii), 63);
        applyStimulus(4'd15);
        checkOutput("lastAscii15", int'(lastAscii), 63);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i));
            checkOutput("tableLastAscii", int'(lastAscii), int'(refAscii(i)));
        end

        for (int i = 0; i < 4; i++) begin
            n = int'($urandom_range(0, 15));
            applyStimulus(4'(n));
            checkOutput("randLastAscii", int'(lastAscii), int'(refAscii(n)));
        end

        applyStimulus(4'd5);
        checkOutput("lastAsciiA", int'(lastAscii), 97);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstTx", int'(txLine), 1);
        checkOutput("rstReady", int'(noteReady), 1);
        checkOutput("rstLastAscii", int'(lastAscii), 0);

        applyStimulus(4'd6);
        checkOutput("lastAsciiAfterRst", int'(lastAscii), 98);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (expQ.size() == 0 && !rxActive && noteReady) break;
        end
        repeat (4) @(posedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        checkOutput("finalIdleTx", int'(txLine), 1);
        if (rxFrames == 0) checkOutput("framesSeen", rxFrames, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
